// File: rtl/client_tile_link_pkg.sv
// -----------------------------------------------------------------------------
// client_tile_link_pkg
// Shared types and helpers for the client TileLink arbiter. The packed structs
// below fix the bit layout of every message on the inner and outer ports.
// Optional feature macro used by the arbiter: CLIENT_TL_ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
package client_tile_link_pkg;

    localparam int NCLIENTS = 2;
    localparam int BEATS    = 8;
    localparam int BEAT_W   = 3;

    localparam logic [2:0] A_TYPE_PUT_BLOCK = 3'b011;
    localparam logic [2:0] REL_DATA_MAX     = 3'd3;

    typedef struct packed {
        logic [25:0] addr_block;
        logic [1:0]  client_xact_id;
        logic [2:0]  addr_beat;
        logic        is_builtin_type;
        logic [2:0]  a_type;
        logic [11:0] union_bits;
        logic [63:0] data;
    } acquire_t;

    typedef struct packed {
        logic [2:0]  addr_beat;
        logic [25:0] addr_block;
        logic [1:0]  client_xact_id;
        logic        voluntary;
        logic [2:0]  r_type;
        logic [63:0] data;
    } release_t;

    typedef struct packed {
        logic [2:0]  addr_beat;
        logic [1:0]  client_xact_id;
        logic        manager_xact_id;
        logic        is_builtin_type;
        logic [3:0]  g_type;
        logic [63:0] data;
        logic        manager_id;
    } grant_t;

    typedef struct packed {
        logic [25:0] addr_block;
        logic [1:0]  p_type;
    } probe_t;

    typedef struct packed {
        logic manager_xact_id;
        logic manager_id;
    } finish_t;

    localparam int ACQ_W = $bits(acquire_t);
    localparam int REL_W = $bits(release_t);
    localparam int GNT_W = $bits(grant_t);
    localparam int PRB_W = $bits(probe_t);
    localparam int FIN_W = $bits(finish_t);

    // A built-in PutBlock carries a full block of data beats
    function automatic logic acq_has_multibeat_data(input acquire_t a);
        return a.is_builtin_type & (a.a_type == A_TYPE_PUT_BLOCK);
    endfunction

    // Release types below REL_DATA_MAX carry a full block of data beats
    function automatic logic rel_has_data(input release_t r);
        return (r.r_type < REL_DATA_MAX);
    endfunction

endpackage

// File: rtl/tl_locking_arbiter.sv
// -----------------------------------------------------------------------------
// tl_locking_arbiter
// Two-way combinational arbiter with burst locking. Once the first beat of a
// multi-beat message fires, the winner owns the channel until BEATS beats have
// fired. Unlocked selection is fixed priority (client 0) by default, or
// alternates with CLIENT_TL_ARB_ROUND_ROBIN_EN defined.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   i_valid[1:0]  : per-client request
//   i_multibeat   : per-client "this message is a multi-beat burst"
//   i_out_ready   : outer channel ready
//   o_sel         : index of the selected client (drives the data mux)
//   o_out_valid   : outer channel valid
//   o_in_ready    : per-client ready, only for the selected valid client
// -----------------------------------------------------------------------------
module tl_locking_arbiter
    import client_tile_link_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_valid,
    input  logic [1:0] i_multibeat,
    input  logic       i_out_ready,
    output logic       o_sel,
    output logic       o_out_valid,
    output logic [1:0] o_in_ready
);

    logic              r_lock;
    logic              r_owner;
    logic [BEAT_W-1:0] r_beat;
    logic              w_pref;
    logic              w_sel;
    logic              w_fire;

`ifdef CLIENT_TL_ARB_ROUND_ROBIN_EN
    // r_pref holds the client favoured next, i.e. the one that did not win last
    logic r_pref;

    // Preference flips away from each client that wins an unlocked first beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pref <= 1'b0;
        end else if (w_fire && !r_lock) begin
            r_pref <= ~w_sel;
        end
    end

    assign w_pref = r_pref;
`else
    assign w_pref = 1'b0;
`endif

    // Select the lock owner, else the preferred valid client, else the other one
    always_comb begin
        w_sel = 1'b0;
        if (r_lock) begin
            w_sel = r_owner;
        end else if (i_valid[w_pref]) begin
            w_sel = w_pref;
        end else if (i_valid[~w_pref]) begin
            w_sel = ~w_pref;
        end else begin
            w_sel = 1'b0;
        end
    end

    assign o_sel       = w_sel;
    assign o_out_valid = i_valid[w_sel];
    assign w_fire      = o_out_valid & i_out_ready;
    assign o_in_ready  = {w_sel & w_fire, ~w_sel & w_fire};

    // Burst lock and beat counter; the lock drops as the last beat fires
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock  <= 1'b0;
            r_owner <= 1'b0;
            r_beat  <= '0;
        end else if (w_fire) begin
            if (r_lock) begin
                r_beat <= r_beat + 3'd1;
                if (r_beat == 3'(BEATS - 1)) begin
                    r_lock <= 1'b0;
                end
            end else if (i_multibeat[w_sel]) begin
                r_lock  <= 1'b1;
                r_owner <= w_sel;
                r_beat  <= 3'd1;
            end
        end
    end

endmodule

// File: rtl/client_tile_link_arbiter.sv
// -----------------------------------------------------------------------------
// client_tile_link_arbiter
// Shares one outer TileLink client port between two inner clients (e.g. I$
// and D$ refill paths). All channels are zero-latency and unbuffered.
//   acquire : locking arbiter, outer id = {client index, inner id[0]}
//   release : locking arbiter, same id tagging, independent lock
//   grant   : routed to the client named by outer client_xact_id[1]; that bit
//             is cleared on the way in
//   finish  : fixed priority to client 0, single beat
//   probe   : pass-through to client 0
// Ports: clk, reset (sync, active high); io_in_* inner per-client channels;
//   io_in0_probe_* client 0 probe; io_out_* outer channels.
// Optional feature macro: CLIENT_TL_ARB_ROUND_ROBIN_EN (alternating unlocked
// selection on acquire and release instead of client 0 priority).
// -----------------------------------------------------------------------------
module client_tile_link_arbiter
    import client_tile_link_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NCLIENTS-1:0]             io_in_acquire_valid,
    output logic [NCLIENTS-1:0]             io_in_acquire_ready,
    input  logic [NCLIENTS-1:0][ACQ_W-1:0]  io_in_acquire_bits,
    input  logic [NCLIENTS-1:0]             io_in_release_valid,
    output logic [NCLIENTS-1:0]             io_in_release_ready,
    input  logic [NCLIENTS-1:0][REL_W-1:0]  io_in_release_bits,
    output logic [NCLIENTS-1:0]             io_in_grant_valid,
    input  logic [NCLIENTS-1:0]             io_in_grant_ready,
    output logic [GNT_W-1:0]                io_in_grant_bits,
    input  logic [NCLIENTS-1:0]             io_in_finish_valid,
    output logic [NCLIENTS-1:0]             io_in_finish_ready,
    input  logic [NCLIENTS-1:0][FIN_W-1:0]  io_in_finish_bits,
    output logic                            io_in0_probe_valid,
    input  logic                            io_in0_probe_ready,
    output logic [PRB_W-1:0]                io_in0_probe_bits,
    output logic                            io_out_acquire_valid,
    input  logic                            io_out_acquire_ready,
    output logic [ACQ_W-1:0]                io_out_acquire_bits,
    output logic                            io_out_release_valid,
    input  logic                            io_out_release_ready,
    output logic [REL_W-1:0]                io_out_release_bits,
    input  logic                            io_out_grant_valid,
    output logic                            io_out_grant_ready,
    input  logic [GNT_W-1:0]                io_out_grant_bits,
    output logic                            io_out_finish_valid,
    input  logic                            io_out_finish_ready,
    output logic [FIN_W-1:0]                io_out_finish_bits,
    input  logic                            io_out_probe_valid,
    output logic                            io_out_probe_ready,
    input  logic [PRB_W-1:0]                io_out_probe_bits
);

    acquire_t [NCLIENTS-1:0] w_acq_in;
    release_t [NCLIENTS-1:0] w_rel_in;
    acquire_t                w_acq_out;
    release_t                w_rel_out;
    logic [NCLIENTS-1:0]     w_acq_mb;
    logic [NCLIENTS-1:0]     w_rel_mb;
    logic                    w_acq_sel;
    logic                    w_rel_sel;
    grant_t                  w_gnt_out;
    grant_t                  w_gnt_in;
    logic                    w_gnt_tag;
    logic                    w_fin_sel;

    assign w_acq_in = io_in_acquire_bits;
    assign w_rel_in = io_in_release_bits;

    // Classify each client's current message as single- or multi-beat
    always_comb begin
        w_acq_mb = '0;
        w_rel_mb = '0;
        for (int k = 0; k < NCLIENTS; k++) begin
            w_acq_mb[k] = acq_has_multibeat_data(w_acq_in[k]);
            w_rel_mb[k] = rel_has_data(w_rel_in[k]);
        end
    end

    tl_locking_arbiter u_acq_arb (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (io_in_acquire_valid),
        .i_multibeat (w_acq_mb),
        .i_out_ready (io_out_acquire_ready),
        .o_sel       (w_acq_sel),
        .o_out_valid (io_out_acquire_valid),
        .o_in_ready  (io_in_acquire_ready)
    );

    tl_locking_arbiter u_rel_arb (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (io_in_release_valid),
        .i_multibeat (w_rel_mb),
        .i_out_ready (io_out_release_ready),
        .o_sel       (w_rel_sel),
        .o_out_valid (io_out_release_valid),
        .o_in_ready  (io_in_release_ready)
    );

    // Outer acquire: selected bits with the client index in the id MSB
    always_comb begin
        w_acq_out                = w_acq_in[w_acq_sel];
        w_acq_out.client_xact_id = {w_acq_sel, w_acq_in[w_acq_sel].client_xact_id[0]};
    end

    // Outer release: selected bits with the client index in the id MSB
    always_comb begin
        w_rel_out                = w_rel_in[w_rel_sel];
        w_rel_out.client_xact_id = {w_rel_sel, w_rel_in[w_rel_sel].client_xact_id[0]};
    end

    assign io_out_acquire_bits = w_acq_out;
    assign io_out_release_bits = w_rel_out;

    // Grant: route on the id MSB, which clients never see set
    assign w_gnt_out = io_out_grant_bits;
    assign w_gnt_tag = w_gnt_out.client_xact_id[1];

    // Inner grant bits are the outer bits with the routing tag cleared
    always_comb begin
        w_gnt_in                   = w_gnt_out;
        w_gnt_in.client_xact_id[1] = 1'b0;
    end

    assign io_in_grant_bits   = w_gnt_in;
    assign io_in_grant_valid  = {io_out_grant_valid & w_gnt_tag, io_out_grant_valid & ~w_gnt_tag};
    assign io_out_grant_ready = io_in_grant_ready[w_gnt_tag];

    // Finish: client 0 always wins, client 1 only when client 0 is idle
    assign w_fin_sel           = ~io_in_finish_valid[0];
    assign io_out_finish_valid = |io_in_finish_valid;
    assign io_out_finish_bits  = io_in_finish_bits[w_fin_sel];
    assign io_in_finish_ready  = {io_in_finish_valid[1] & ~io_in_finish_valid[0] & io_out_finish_ready,
                                  io_in_finish_valid[0] & io_out_finish_ready};

    // Probe goes to client 0 only
    assign io_in0_probe_valid = io_out_probe_valid;
    assign io_in0_probe_bits  = io_out_probe_bits;
    assign io_out_probe_ready = io_in0_probe_ready;

endmodule

// File: tb/tb_client_tile_link_arbiter.sv
module tb_client_tile_link_arbiter;

    localparam int NCYC  = 3000;
    localparam int BEATS = 8;
`ifdef CLIENT_TL_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic [1:0]            io_in_acquire_valid;
    logic [1:0]            io_in_acquire_ready;
    logic [1:0][110:0]     io_in_acquire_bits;
    logic [1:0]            io_in_release_valid;
    logic [1:0]            io_in_release_ready;
    logic [1:0][98:0]      io_in_release_bits;
    logic [1:0]            io_in_grant_valid;
    logic [1:0]            io_in_grant_ready;
    logic [75:0]           io_in_grant_bits;
    logic [1:0]            io_in_finish_valid;
    logic [1:0]            io_in_finish_ready;
    logic [1:0][1:0]       io_in_finish_bits;
    logic                  io_in0_probe_valid;
    logic                  io_in0_probe_ready;
    logic [27:0]           io_in0_probe_bits;
    logic                  io_out_acquire_valid;
    logic                  io_out_acquire_ready;
    logic [110:0]          io_out_acquire_bits;
    logic                  io_out_release_valid;
    logic                  io_out_release_ready;
    logic [98:0]           io_out_release_bits;
    logic                  io_out_grant_valid;
    logic                  io_out_grant_ready;
    logic [75:0]           io_out_grant_bits;
    logic                  io_out_finish_valid;
    logic                  io_out_finish_ready;
    logic [1:0]            io_out_finish_bits;
    logic                  io_out_probe_valid;
    logic                  io_out_probe_ready;
    logic [27:0]           io_out_probe_bits;

    client_tile_link_arbiter dut (
        .clk                  (clk),
        .reset                (reset),
        .io_in_acquire_valid  (io_in_acquire_valid),
        .io_in_acquire_ready  (io_in_acquire_ready),
        .io_in_acquire_bits   (io_in_acquire_bits),
        .io_in_release_valid  (io_in_release_valid),
        .io_in_release_ready  (io_in_release_ready),
        .io_in_release_bits   (io_in_release_bits),
        .io_in_grant_valid    (io_in_grant_valid),
        .io_in_grant_ready    (io_in_grant_ready),
        .io_in_grant_bits     (io_in_grant_bits),
        .io_in_finish_valid   (io_in_finish_valid),
        .io_in_finish_ready   (io_in_finish_ready),
        .io_in_finish_bits    (io_in_finish_bits),
        .io_in0_probe_valid   (io_in0_probe_valid),
        .io_in0_probe_ready   (io_in0_probe_ready),
        .io_in0_probe_bits    (io_in0_probe_bits),
        .io_out_acquire_valid (io_out_acquire_valid),
        .io_out_acquire_ready (io_out_acquire_ready),
        .io_out_acquire_bits  (io_out_acquire_bits),
        .io_out_release_valid (io_out_release_valid),
        .io_out_release_ready (io_out_release_ready),
        .io_out_release_bits  (io_out_release_bits),
        .io_out_grant_valid   (io_out_grant_valid),
        .io_out_grant_ready   (io_out_grant_ready),
        .io_out_grant_bits    (io_out_grant_bits),
        .io_out_finish_valid  (io_out_finish_valid),
        .io_out_finish_ready  (io_out_finish_ready),
        .io_out_finish_bits   (io_out_finish_bits),
        .io_out_probe_valid   (io_out_probe_valid),
        .io_out_probe_ready   (io_out_probe_ready),
        .io_out_probe_bits    (io_out_probe_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected combinational view of one cycle
    typedef struct {
        logic        acq_v;
        logic [1:0]  acq_r;
        logic        rel_v;
        logic [1:0]  rel_r;
        logic [1:0]  gnt_v;
        logic [75:0] gnt_b;
        logic        gnt_r;
        logic        fin_v;
        logic [1:0]  fin_r;
        logic [1:0]  fin_b;
        logic        prb_v;
        logic [27:0] prb_b;
        logic        prb_r;
    } exp_t;

    exp_t          exp_q[$];
    logic [110:0]  acq_q[$];
    logic [98:0]   rel_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    // Client-side message state, [channel][client], channel 0 = acquire, 1 = release
    bit            pend   [2][2];
    bit            burst  [2][2];
    int            left   [2][2];
    logic [25:0]   s_addr [2][2];
    logic [1:0]    s_id   [2][2];
    logic [2:0]    s_typ  [2][2];
    logic          s_flag [2][2];
    logic [11:0]   s_uni  [2][2];
    logic [2:0]    s_beat [2][2];
    logic [63:0]   s_data [2][2];

    // Reference model: who owns a burst, how many beats remain, who is favoured next
    int            m_owner[2];
    int            m_left [2];
    int            m_pref [2];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [110:0] cur_acq(input int k, input logic [1:0] id);
        return {s_addr[0][k], id, s_beat[0][k], s_flag[0][k], s_typ[0][k], s_uni[0][k], s_data[0][k]};
    endfunction

    function automatic logic [98:0] cur_rel(input int k, input logic [1:0] id);
        return {s_beat[1][k], s_addr[1][k], id, s_flag[1][k], s_typ[1][k], s_data[1][k]};
    endfunction

    task automatic new_msg(input int ch, input int k, input bit force_get);
        int kind;
        pend[ch][k]   = 1'b1;
        s_addr[ch][k] = 26'($urandom);
        s_id[ch][k]   = 2'($urandom_range(0, 3));
        s_uni[ch][k]  = 12'($urandom);
        s_beat[ch][k] = 3'd0;
        s_data[ch][k] = {$urandom, $urandom};
        s_flag[ch][k] = 1'($urandom_range(0, 1));
        if (ch == 0) begin
            kind = force_get ? 0 : int'($urandom_range(0, 3));
            case (kind)
                0: begin s_flag[0][k] = 1'b1; s_typ[0][k] = 3'd0; end
                1: begin s_flag[0][k] = 1'b1; s_typ[0][k] = 3'd3; end
                2: begin s_flag[0][k] = 1'b1; s_typ[0][k] = 3'($urandom_range(4, 7)); end
                default: begin s_flag[0][k] = 1'b0; s_typ[0][k] = 3'd3; end
            endcase
            burst[0][k] = (kind == 1);
            if (force_get) s_id[0][k] = 2'd1;
        end else begin
            s_typ[1][k] = 3'($urandom_range(0, 7));
            burst[1][k] = (s_typ[1][k] < 3'd3);
        end
        left[ch][k] = burst[ch][k] ? BEATS : 1;
    endtask

    task automatic advance(input int ch, input int k);
        if (left[ch][k] > 1) begin
            left[ch][k]   = left[ch][k] - 1;
            s_beat[ch][k] = s_beat[ch][k] + 3'd1;
            s_data[ch][k] = {$urandom, $urandom};
        end else begin
            pend[ch][k] = 1'b0;
        end
    endtask

    // Monitor: compare each cycle's outputs and every fired outer beat
    exp_t me;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            check("acq_out_valid", 128'(io_out_acquire_valid), 128'(me.acq_v));
            check("acq_in_ready",  128'(io_in_acquire_ready),  128'(me.acq_r));
            check("rel_out_valid", 128'(io_out_release_valid), 128'(me.rel_v));
            check("rel_in_ready",  128'(io_in_release_ready),  128'(me.rel_r));
            check("gnt_in_valid",  128'(io_in_grant_valid),    128'(me.gnt_v));
            check("gnt_out_ready", 128'(io_out_grant_ready),   128'(me.gnt_r));
            if (me.gnt_v != 2'b00) check("gnt_in_bits", 128'(io_in_grant_bits), 128'(me.gnt_b));
            check("fin_out_valid", 128'(io_out_finish_valid),  128'(me.fin_v));
            check("fin_in_ready",  128'(io_in_finish_ready),   128'(me.fin_r));
            if (me.fin_v) check("fin_out_bits", 128'(io_out_finish_bits), 128'(me.fin_b));
            check("prb_valid",     128'(io_in0_probe_valid),   128'(me.prb_v));
            check("prb_ready",     128'(io_out_probe_ready),   128'(me.prb_r));
            if (me.prb_v) check("prb_bits", 128'(io_in0_probe_bits), 128'(me.prb_b));
        end
        if (io_out_acquire_valid && io_out_acquire_ready) begin
            if (acq_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL acq_fire: got unexpected beat %h expected none", io_out_acquire_bits);
            end else begin
                check("acq_out_bits", 128'(io_out_acquire_bits), 128'(acq_q.pop_front()));
            end
        end
        if (io_out_release_valid && io_out_release_ready) begin
            if (rel_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rel_fire: got unexpected beat %h expected none", io_out_release_bits);
            end else begin
                check("rel_out_bits", 128'(io_out_release_bits), 128'(rel_q.pop_front()));
            end
        end
    end

    // Driver and reference model
    initial begin
        exp_t        e;
        logic [1:0]  v [2];
        logic        ordy [2];
        bit          do_rst, force_both, did_mid, post_mid;
        int          win, pref;
        logic [2:0]  g_beat;
        logic [1:0]  g_id;
        logic        g_mx, g_bt, g_mid;
        logic [3:0]  g_type;
        logic [63:0] g_data;

        did_mid  = 1'b0;
        post_mid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_owner[c] = -1; m_left[c] = 0; m_pref[c] = 0;
            for (int k = 0; k < 2; k++) pend[c][k] = 1'b0;
        end
        reset                = 1'b1;
        io_in_acquire_valid  = '0; io_in_acquire_bits = '0;
        io_in_release_valid  = '0; io_in_release_bits = '0;
        io_in_grant_ready    = '0; io_in_finish_valid = '0; io_in_finish_bits = '0;
        io_in0_probe_ready   = 1'b0;
        io_out_acquire_ready = 1'b0; io_out_release_ready = 1'b0;
        io_out_grant_valid   = 1'b0; io_out_grant_bits = '0;
        io_out_finish_ready  = 1'b0;
        io_out_probe_valid   = 1'b0; io_out_probe_bits = '0;
        @(posedge clk); #1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            do_rst     = (cyc < 2) || (!did_mid && cyc >= 1000 && m_owner[0] >= 0 && m_left[0] <= 4);
            force_both = (cyc == 2) || post_mid;
            post_mid   = 1'b0;
            g_beat = '0; g_id = '0; g_mx = 1'b0; g_bt = 1'b0; g_type = '0; g_data = '0; g_mid = 1'b0;
            if (do_rst) begin
                reset = 1'b1;
                v[0] = 2'b00; v[1] = 2'b00; ordy[0] = 1'b0; ordy[1] = 1'b0;
                io_out_grant_valid = 1'b0; io_in_grant_ready = 2'b00;
                io_in_finish_valid = 2'b00; io_out_finish_ready = 1'b0;
                io_out_probe_valid = 1'b0; io_in0_probe_ready = 1'b0;
            end else begin
                reset = 1'b0;
                if (force_both) begin
                    new_msg(0, 0, 1'b1);
                    new_msg(0, 1, 1'b1);
                end
                for (int c = 0; c < 2; c++)
                    for (int k = 0; k < 2; k++)
                        if (!pend[c][k] && $urandom_range(0, 3) == 0) new_msg(c, k, 1'b0);
                for (int c = 0; c < 2; c++) begin
                    for (int k = 0; k < 2; k++)
                        v[c][k] = pend[c][k] && (force_both || $urandom_range(0, 9) != 0);
                    ordy[c] = (force_both && c == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                end
                g_beat = 3'($urandom); g_id = 2'($urandom); g_mx = 1'($urandom);
                g_bt = 1'($urandom); g_type = 4'($urandom); g_data = {$urandom, $urandom};
                g_mid = 1'($urandom);
                io_out_grant_valid = 1'($urandom_range(0, 1));
                if (cyc == 2) begin
                    g_id = 2'b10; g_data = 64'h0000_0000_DEAD_BEEF; io_out_grant_valid = 1'b1;
                end
                io_in_grant_ready   = 2'($urandom);
                io_in_finish_valid  = 2'($urandom);
                io_in_finish_bits   = 4'($urandom);
                io_out_finish_ready = 1'($urandom);
                io_out_probe_valid  = 1'($urandom);
                io_out_probe_bits   = 28'($urandom);
                io_in0_probe_ready  = 1'($urandom);
            end
            io_out_grant_bits = {g_beat, g_id, g_mx, g_bt, g_type, g_data, g_mid};
            io_in_acquire_valid  = v[0];
            io_in_release_valid  = v[1];
            io_out_acquire_ready = ordy[0];
            io_out_release_ready = ordy[1];
            for (int k = 0; k < 2; k++) begin
                io_in_acquire_bits[k] = cur_acq(k, s_id[0][k]);
                io_in_release_bits[k] = cur_rel(k, s_id[1][k]);
            end
            #1;

            // Acquire and release: a burst owner keeps the channel for all its beats
            for (int c = 0; c < 2; c++) begin
                pref = RR_EN ? m_pref[c] : 0;
                win  = -1;
                if (m_owner[c] >= 0) begin
                    if (v[c][m_owner[c]]) win = m_owner[c];
                end else if (v[c] == 2'b11) begin
                    win = pref;
                end else if (v[c][0]) begin
                    win = 0;
                end else if (v[c][1]) begin
                    win = 1;
                end
                if (c == 0) begin
                    e.acq_v = (win >= 0);
                    e.acq_r = (win >= 0 && ordy[c]) ? 2'(1 << win) : 2'b00;
                end else begin
                    e.rel_v = (win >= 0);
                    e.rel_r = (win >= 0 && ordy[c]) ? 2'(1 << win) : 2'b00;
                end
                if (win >= 0 && ordy[c]) begin
                    if (c == 0) acq_q.push_back(cur_acq(win, {win[0], s_id[0][win][0]}));
                    else        rel_q.push_back(cur_rel(win, {win[0], s_id[1][win][0]}));
                    if (m_owner[c] >= 0) begin
                        m_left[c] = m_left[c] - 1;
                        if (m_left[c] == 0) m_owner[c] = -1;
                    end else begin
                        if (burst[c][win]) begin
                            m_owner[c] = win;
                            m_left[c]  = BEATS - 1;
                        end
                        m_pref[c] = 1 - win;
                    end
                    advance(c, win);
                end
            end

            e.gnt_v = io_out_grant_valid ? (g_id[1] ? 2'b10 : 2'b01) : 2'b00;
            e.gnt_b = {g_beat, 1'b0, g_id[0], g_mx, g_bt, g_type, g_data, g_mid};
            e.gnt_r = io_in_grant_ready[g_id[1]];
            e.fin_v = |io_in_finish_valid;
            e.fin_r = io_in_finish_valid[0] ? {1'b0, io_out_finish_ready} :
                      (io_in_finish_valid[1] ? {io_out_finish_ready, 1'b0} : 2'b00);
            e.fin_b = io_in_finish_valid[0] ? io_in_finish_bits[0] : io_in_finish_bits[1];
            e.prb_v = io_out_probe_valid;
            e.prb_b = io_out_probe_bits;
            e.prb_r = io_in0_probe_ready;
            exp_q.push_back(e);

            if (do_rst) begin
                for (int c = 0; c < 2; c++) begin
                    m_owner[c] = -1; m_left[c] = 0; m_pref[c] = 0;
                    for (int k = 0; k < 2; k++) pend[c][k] = 1'b0;
                end
                if (cyc >= 2) begin
                    did_mid  = 1'b1;
                    post_mid = 1'b1;
                end
            end
            @(posedge clk); #1;
        end

        reset = 1'b0;
        io_in_acquire_valid = '0; io_in_release_valid = '0;
        @(negedge clk); #1;
        check("mid_burst_reset_seen", 128'(did_mid), 128'(1'b1));
        check("exp_q_drained", 128'(exp_q.size()), 128'(0));
        check("acq_q_drained", 128'(acq_q.size()), 128'(0));
        check("rel_q_drained", 128'(rel_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
